mc_fsm_ctrl: RTL
================

MC_FSM_CTRL -- requirements
Module: mc_fsm_ctrl

Interface
REQ-001 SHALL provide parameter PC_W, default 32, PC and address width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h1c000000, first fetch address.
REQ-003 SHALL provide parameter WAIT_MAX, default 16, maximum cycles to wait for a handshake ack; 0 disables the timeout.
REQ-004 SHALL provide parameter CNT_W, default 32, performance counter width.
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  out  1  fetch request.
- inst_addr  out  PC_W  fetch address (equals pc).
- inst_ack  in  1  inst_rdata valid this cycle.
- inst_rdata  in  32  fetched instruction.
- ir  out  32  instruction register.
- dec_is_br  in  1  branch with no register write (b/beq/bne).
- dec_is_ld  in  1  load.
- dec_is_st  in  1  store.
- dec_gr_we  in  1  instruction writes the GPR.
- br_taken  in  1  redirect taken.
- br_target  in  PC_W  redirect target.
- data_req  out  1  data access request.
- data_we  out  1  data write.
- data_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- pc  out  PC_W  current instruction PC.
- state  out  3  FSM state encoding.
- retire  out  1  one-cycle pulse per completed instruction.
- bus_err  out  1  sticky timeout flag.
- cycle_cnt  out  CNT_W  cycle counter.
- instret_cnt  out  CNT_W  retired-instruction counter.

Function
REQ-006 SHALL encode states as IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=7.
REQ-007 IF: inst_req=1; hold IF until inst_ack; on ack, ir<=inst_rdata and go to ID.
REQ-008 ID: if dec_is_br, pc<=br_taken?br_target:pc+4, pulse retire, go to IF; otherwise go to EXE.
REQ-009 EXE: one cycle; go to MEM if dec_is_ld|dec_is_st, else go to WB.
REQ-010 MEM: data_req=1, data_we=dec_is_st; hold until data_ack; on ack, a store updates pc (pc+4), pulses retire and goes to IF; a load goes to WB.
REQ-011 WB: rf_we=dec_gr_we for exactly one cycle; pc<=br_taken?br_target:pc+4; pulse retire; go to IF.
REQ-012 inst_req, data_req, data_we and rf_we SHALL be combinational from state only and 0 outside their states.
REQ-013 PC arithmetic SHALL be modulo 2^PC_W, so pc=all-ones-minus-3 plus 4 wraps to 0.
REQ-014 A wait counter SHALL count consecutive cycles with a request high and its ack low; it clears on ack or on a state change.
REQ-015 When WAIT_MAX!=0 and the counter reaches WAIT_MAX with no ack, SHALL enter HALT and set bus_err=1.
REQ-016 An ack arriving in the same cycle as the timeout SHALL win: normal transition, no error.
REQ-017 HALT SHALL be absorbing: all requests 0, pc frozen, exit only by reset.
REQ-018 Minimum latency: branch 2 cycles, ALU op 4, store 4, load 5, with zero-wait acks.

Reset
REQ-019 On resetn=0, SHALL asynchronously set state=IF, pc=RESET_PC, ir=0, wait counter=0, bus_err=0 and counters=0.
REQ-020 Reset asserted mid-access SHALL abort the access with no retire pulse; the first inst_req after release SHALL occur in the first cycle after deassertion.

Configuration
REQ-021 With MC_PERF_CNT_EN defined: cycle_cnt increments every cycle outside HALT; instret_cnt increments on each retire; both wrap modulo 2^CNT_W.
REQ-022 Without MC_PERF_CNT_EN: both counter outputs are constant 0 and no counter flops are built; ports remain.

Verification
REQ-023 Reset release, inst_ack same cycle, ALU op with dec_gr_we=1 -> inst_addr=32'h1c000000, rf_we high in cycle 4 only, pc=32'h1c000004, retire once.
REQ-024 beq with br_taken=1, br_target=32'h1c000100 -> state path IF,ID,IF; rf_we never high; next inst_addr=32'h1c000100.
REQ-025 Load with data_ack delayed 3 cycles -> data_req high 4 cycles, data_we=0, then WB with rf_we=1, total 8 cycles.
REQ-026 WAIT_MAX=4, inst_ack never asserted -> HALT after 4 IF wait cycles, bus_err=1, inst_req=0; ack on the 4th cycle instead -> no error.
REQ-027 resetn pulled low during MEM of a store -> data_req drops immediately, pc=RESET_PC, retire not pulsed.
REQ-028 MC_PERF_CNT_EN defined, 10 ALU ops with zero-wait acks -> instret_cnt=10, cycle_cnt=40; undefined -> both 0.

Source files
------------

// File: rtl/mc_fsm_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller with bus timeout.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mc_fsm_ctrl #(
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = 'h1c000000,
  parameter int                WAIT_MAX = 16,
  parameter int                CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  output logic [PC_W-1:0]  inst_addr,
  input  logic             inst_ack,
  input  logic [31:0]      inst_rdata,
  output logic [31:0]      ir,
  input  logic             dec_is_br,
  input  logic             dec_is_ld,
  input  logic             dec_is_st,
  input  logic             dec_gr_we,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic             data_req,
  output logic             data_we,
  input  logic             data_ack,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       state,
  output logic             retire,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam logic [31:0] WMAX = 32'(WAIT_MAX);

  state_t          cur, nxt;
  logic [31:0]     wait_cnt;
  logic [PC_W-1:0] pc_inc, pc_nxt;
  logic            pc_ld, ir_ld, waiting, tmo;

  assign state     = cur;
  assign inst_addr = pc;
  assign pc_inc    = pc + PC_W'(4);

  assign inst_req = (cur == S_IF);
  assign data_req = (cur == S_MEM);
  assign data_we  = (cur == S_MEM) & dec_is_st;
  assign rf_we    = (cur == S_WB) & dec_gr_we;

  always_comb begin
    nxt     = cur;
    ir_ld   = 1'b0;
    pc_ld   = 1'b0;
    pc_nxt  = pc_inc;
    retire  = 1'b0;
    waiting = 1'b0;
    tmo     = 1'b0;
    unique case (cur)
      S_IF: begin
        if (inst_ack) begin
          ir_ld = 1'b1;
          nxt   = S_ID;
        end else begin
          waiting = 1'b1;
        end
      end
      S_ID: begin
        if (dec_is_br) begin
          pc_ld  = 1'b1;
          pc_nxt = br_taken ? br_target : pc_inc;
          retire = 1'b1;
          nxt    = S_IF;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: nxt = (dec_is_ld | dec_is_st) ? S_MEM : S_WB;
      S_MEM: begin
        if (data_ack) begin
          if (dec_is_st) begin
            pc_ld  = 1'b1;
            retire = 1'b1;
            nxt    = S_IF;
          end else begin
            nxt = S_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        pc_ld  = 1'b1;
        pc_nxt = br_taken ? br_target : pc_inc;
        retire = 1'b1;
        nxt    = S_IF;
      end
      default: nxt = S_HALT;
    endcase
    // a same-cycle ack clears waiting, so it always beats the timeout
    if (waiting && (WAIT_MAX != 0) && (wait_cnt + 32'd1 == WMAX)) begin
      tmo = 1'b1;
      nxt = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur      <= S_IF;
      pc       <= RESET_PC;
      ir       <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      cur <= nxt;
      if (ir_ld) ir <= inst_rdata;
      if (pc_ld) pc <= pc_nxt;
      wait_cnt <= (waiting && nxt == cur) ? wait_cnt + 32'd1 : '0;
      if (tmo) bus_err <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (cur != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (retire) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
